// File: rtl/synth_pkg.sv
// Shared types and constants for the PS/2 note decoder: receiver and
// decoder state encodings, scan codes, phase steps and the code-to-step map.
package synth_pkg;

   typedef enum logic [1:0] {
      RX_IDLE   = 2'd0,
      RX_DATA   = 2'd1,
      RX_PARITY = 2'd2,
      RX_STOP   = 2'd3
   } rx_state_e;

   typedef enum logic [1:0] {
      DEC_NORMAL    = 2'd0,
      DEC_BREAK     = 2'd1,
      DEC_EXT       = 2'd2,
      DEC_EXT_BREAK = 2'd3
   } dec_state_e;

   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_C4    = 8'h1C;
   localparam logic [7:0] SC_D4    = 8'h1B;
   localparam logic [7:0] SC_E4    = 8'h23;
   localparam logic [7:0] SC_F4    = 8'h2B;
   localparam logic [7:0] SC_G4    = 8'h34;
   localparam logic [7:0] SC_A4    = 8'h33;
   localparam logic [7:0] SC_B4    = 8'h3B;
   localparam logic [7:0] SC_C5    = 8'h42;

   // step = round(1.25 * f_note)
   localparam logic [15:0] STEP_C4 = 16'd327;
   localparam logic [15:0] STEP_D4 = 16'd367;
   localparam logic [15:0] STEP_E4 = 16'd412;
   localparam logic [15:0] STEP_F4 = 16'd437;
   localparam logic [15:0] STEP_G4 = 16'd490;
   localparam logic [15:0] STEP_A4 = 16'd550;
   localparam logic [15:0] STEP_B4 = 16'd617;
   localparam logic [15:0] STEP_C5 = 16'd654;

   typedef struct packed {
      logic        hit;
      logic [15:0] step;
   } note_res_t;

   function automatic note_res_t note_step(input logic [7:0] code);
      note_res_t r;
      r.hit  = 1'b1;
      r.step = '0;
      case (code)
         SC_C4:   r.step = STEP_C4;
         SC_D4:   r.step = STEP_D4;
         SC_E4:   r.step = STEP_E4;
         SC_F4:   r.step = STEP_F4;
         SC_G4:   r.step = STEP_G4;
         SC_A4:   r.step = STEP_A4;
         SC_B4:   r.step = STEP_B4;
         SC_C5:   r.step = STEP_C5;
         default: r.hit  = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: 2-FF synchronisers, falling-edge detect, frame FSM
// and inactivity timeout. Optional macro PS2_PARITY_CHECK_EN enables the
// odd-parity check; without it only the stop bit qualifies a frame.
//
// state     | meaning
// ----------+------------------------------------------------
// RX_IDLE   | waiting for a start bit (data 0 on a falling edge)
// RX_DATA   | shifting in 8 data bits, LSB first
// RX_PARITY | capturing the parity bit
// RX_STOP   | checking the stop bit, then back to idle
module ps2_rx
   import synth_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 2048
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       ps2_clk_i,
   input  logic       ps2_dat_i,
   output logic [7:0] byte_o,
   output logic       byte_valid_o,
   output logic       frame_err_o
);

   localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   // [0],[1] synchroniser stages, [2] previous synchronised value for edge detect
   logic [2:0]  clk_sync_q;
   logic [1:0]  dat_sync_q;
   logic        fall, dat;
   rx_state_e   state_q, state_d;
   logic [7:0]  sh_q;
   logic [2:0]  cnt_q;
   logic        par_q;
   logic [TW-1:0] tmr_q;
   logic        timeout, frame_ok;
   logic        byte_valid_d, frame_err_d, byte_valid_q, frame_err_q;

   assign fall    = clk_sync_q[2] & ~clk_sync_q[1];
   assign dat     = dat_sync_q[1];
   assign timeout = (state_q != RX_IDLE) && (tmr_q == '0);

`ifdef PS2_PARITY_CHECK_EN
   assign frame_ok = dat & (^{sh_q, par_q});
`else
   assign frame_ok = dat;
`endif

   // Synchronisers idle high, matching the PS/2 bus idle level
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         clk_sync_q <= 3'b111;
         dat_sync_q <= 2'b11;
      end else begin
         clk_sync_q <= {clk_sync_q[1:0], ps2_clk_i};
         dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
      end
   end

   // Receiver state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= RX_IDLE;
      else         state_q <= state_d;
   end

   // Receiver next state; timeout overrides any bus activity
   always_comb begin
      state_d = state_q;
      if (timeout) begin
         state_d = RX_IDLE;
      end else if (fall) begin
         case (state_q)
            RX_IDLE:   if (!dat) state_d = RX_DATA;
            RX_DATA:   if (cnt_q == 3'd7) state_d = RX_PARITY;
            RX_PARITY: state_d = RX_STOP;
            RX_STOP:   state_d = RX_IDLE;
            default:   state_d = RX_IDLE;
         endcase
      end
   end

   // Receiver outputs: frame verdict at the stop-bit edge, or timeout error
   always_comb begin
      byte_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      if (timeout) begin
         frame_err_d = 1'b1;
      end else if (fall && state_q == RX_STOP) begin
         byte_valid_d = frame_ok;
         frame_err_d  = ~frame_ok;
      end
   end

   // Shift register, bit counter, parity capture, timeout down-counter
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sh_q         <= '0;
         cnt_q        <= '0;
         par_q        <= 1'b0;
         tmr_q        <= TW'(TIMEOUT_CYC - 1);
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         byte_valid_q <= byte_valid_d;
         frame_err_q  <= frame_err_d;
         if (state_q == RX_IDLE || fall) tmr_q <= TW'(TIMEOUT_CYC - 1);
         else if (tmr_q != '0)           tmr_q <= tmr_q - 1'b1;
         if (timeout) begin
            sh_q  <= '0;
            cnt_q <= '0;
         end else if (state_q == RX_IDLE) begin
            cnt_q <= '0;
         end else if (fall && state_q == RX_DATA) begin
            sh_q  <= {dat, sh_q[7:1]};
            cnt_q <= cnt_q + 3'd1;
         end else if (fall && state_q == RX_PARITY) begin
            par_q <= dat;
         end
      end
   end

   assign byte_o       = sh_q;
   assign byte_valid_o = byte_valid_q;
   assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/ps2_note_decoder.sv
// PS/2 keyboard to note gate/step decoder for the codec. Handles make,
// break and extended prefixes for eight note keys with last-key priority.
// Optional macro PS2_PARITY_CHECK_EN (passed through to ps2_rx).
//
// state         | meaning
// --------------+------------------------------------------
// DEC_NORMAL    | next byte is a make code or a prefix
// DEC_BREAK     | next byte is a break code
// DEC_EXT       | E0 seen; F0 or an ignored extended make follows
// DEC_EXT_BREAK | E0 F0 seen; next byte is ignored
module ps2_note_decoder
   import synth_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 2048
) (
   input  logic        iCLK_18_4,
   input  logic        iRST_N,
   input  logic        iPS2_CLK,
   input  logic        iPS2_DAT,
   output logic        oKEY_ON,
   output logic [15:0] oSTEP,
   output logic        oFRAME_ERR
);

   logic [7:0]  rx_byte;
   logic        rx_valid, rx_err;
   note_res_t   note;
   dec_state_e  state_q, state_d;
   logic        key_on_q, key_on_d;
   logic [15:0] step_q, step_d;
   logic [7:0]  held_q, held_d;
   logic        frame_err_q;

   ps2_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
      .clk_i        (iCLK_18_4),
      .rst_ni       (iRST_N),
      .ps2_clk_i    (iPS2_CLK),
      .ps2_dat_i    (iPS2_DAT),
      .byte_o       (rx_byte),
      .byte_valid_o (rx_valid),
      .frame_err_o  (rx_err)
   );

   assign note = note_step(rx_byte);

   // Decoder state and output registers
   always_ff @(posedge iCLK_18_4 or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q     <= DEC_NORMAL;
         key_on_q    <= 1'b0;
         step_q      <= '0;
         held_q      <= 8'h00;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         key_on_q    <= key_on_d;
         step_q      <= step_d;
         held_q      <= held_d;
         frame_err_q <= rx_err;
      end
   end

   // Decoder next state, advanced once per received byte
   always_comb begin
      state_d = state_q;
      if (rx_valid) begin
         case (state_q)
            DEC_NORMAL: begin
               if (rx_byte == SC_BREAK)    state_d = DEC_BREAK;
               else if (rx_byte == SC_EXT) state_d = DEC_EXT;
            end
            DEC_EXT:  state_d = (rx_byte == SC_BREAK) ? DEC_EXT_BREAK : DEC_NORMAL;
            default:  state_d = DEC_NORMAL;
         endcase
      end
   end

   // Gate/step/held-code update; a repeat of the held key rewrites identical values
   always_comb begin
      key_on_d = key_on_q;
      step_d   = step_q;
      held_d   = held_q;
      if (rx_valid) begin
         case (state_q)
            DEC_NORMAL: begin
               if (rx_byte != SC_BREAK && rx_byte != SC_EXT && note.hit) begin
                  key_on_d = 1'b1;
                  step_d   = note.step;
                  held_d   = rx_byte;
               end
            end
            DEC_BREAK: if (rx_byte == held_q) key_on_d = 1'b0;
            default: ;
         endcase
      end
   end

   assign oKEY_ON    = key_on_q;
   assign oSTEP      = step_q;
   assign oFRAME_ERR = frame_err_q;

endmodule

// File: tb/tb_ps2_note_decoder.sv
// Directed bench for ps2_note_decoder: make/break/typematic/extended codes,
// parity and stop-bit errors, timeout, latency and mid-frame reset.
module tb_ps2_note_decoder;

   logic        iCLK_18_4 = 1'b0;
   logic        iRST_N    = 1'b0;
   logic        iPS2_CLK  = 1'b1;
   logic        iPS2_DAT  = 1'b1;
   logic        oKEY_ON;
   logic [15:0] oSTEP;
   logic        oFRAME_ERR;

   int n_chk = 0;
   int n_err = 0;

   int err_pulses  = 0;
   int err_run     = 0;
   int err_run_max = 0;
   int key_falls   = 0;
   logic key_prev  = 1'b0;

   always #5 iCLK_18_4 = ~iCLK_18_4;

   ps2_note_decoder #(.TIMEOUT_CYC(2048)) dut (
      .iCLK_18_4  (iCLK_18_4),
      .iRST_N     (iRST_N),
      .iPS2_CLK   (iPS2_CLK),
      .iPS2_DAT   (iPS2_DAT),
      .oKEY_ON    (oKEY_ON),
      .oSTEP      (oSTEP),
      .oFRAME_ERR (oFRAME_ERR)
   );

   always @(negedge iCLK_18_4) begin
      if (oFRAME_ERR) begin
         err_pulses++;
         err_run++;
         if (err_run > err_run_max) err_run_max = err_run;
      end else begin
         err_run = 0;
      end
      if (key_prev && !oKEY_ON) key_falls++;
      key_prev = oKEY_ON;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge iCLK_18_4);
   endtask

   task automatic ps2_bit(input logic v);
      wait_clk(1);
      iPS2_DAT = v;
      wait_clk(10);
      iPS2_CLK = 1'b0;
      wait_clk(20);
      iPS2_CLK = 1'b1;
      wait_clk(9);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit stop_v,
                             input bit lat, input logic pre_k, input logic [15:0] pre_s,
                             input logic post_k, input logic [15:0] post_s);
      logic par;
      par = (~^b) ^ flip_par;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit(par);
      wait_clk(1);
      iPS2_DAT = stop_v;
      wait_clk(10);
      iPS2_CLK = 1'b0;
      if (lat) begin
         repeat (3) @(posedge iCLK_18_4);
         #1;
         chk("lat3_key", oKEY_ON, pre_k);
         chk("lat3_step", oSTEP, pre_s);
         @(posedge iCLK_18_4);
         #1;
         chk("lat4_key", oKEY_ON, post_k);
         chk("lat4_step", oSTEP, post_s);
      end
      wait_clk(20);
      iPS2_CLK = 1'b1;
      iPS2_DAT = 1'b1;
      wait_clk(20);
   endtask

   task automatic send(input logic [7:0] b);
      send_frame(b, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 16'd0);
   endtask

   task automatic expect_out(input string tag, input logic k, input logic [15:0] s);
      chk({tag, "_key"}, oKEY_ON, k);
      chk({tag, "_step"}, oSTEP, s);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog sim time exceeded");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      logic [15:0] exp_step;

      wait_clk(5);
      chk("rst_key", oKEY_ON, 1'b0);
      chk("rst_step", oSTEP, 16'd0);
      chk("rst_err", oFRAME_ERR, 1'b0);
      iRST_N = 1'b1;
      wait_clk(5);

      // first make, exact 4-cycle latency from stop edge
      send_frame(8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 1'b1, 16'd550);
      expect_out("a4_make", 1'b1, 16'd550);
      send(8'hF0); send(8'h33);
      expect_out("a4_break", 1'b0, 16'd550);

      // typematic repeat must never drop the gate
      send(8'h1C);
      expect_out("c4_make", 1'b1, 16'd327);
      base = key_falls;
      for (int i = 0; i < 5; i++) begin
         send(8'h1C);
         expect_out("c4_rep", 1'b1, 16'd327);
      end
      send(8'hF0);
      expect_out("c4_f0", 1'b1, 16'd327);
      send(8'h1C);
      expect_out("c4_break", 1'b0, 16'd327);
      chk("c4_falls", key_falls - base, 1);

      // last-key priority, stale break ignored
      send(8'h1C);
      expect_out("lk_c4", 1'b1, 16'd327);
      base = key_falls;
      send(8'h42);
      expect_out("lk_c5", 1'b1, 16'd654);
      send(8'hF0); send(8'h1C);
      expect_out("lk_oldbrk", 1'b1, 16'd654);
      chk("lk_falls", key_falls - base, 0);
      send(8'hF0); send(8'h42);
      expect_out("lk_brk", 1'b0, 16'd654);

      // extended codes and unmapped make ignored
      send(8'hE0); send(8'hF0); send(8'h33);
      expect_out("ext_brk", 1'b0, 16'd654);
      send(8'hE0); send(8'h33);
      expect_out("ext_make", 1'b0, 16'd654);
      send(8'h15);
      expect_out("unmapped", 1'b0, 16'd654);
      send(8'h23);
      expect_out("e4_make", 1'b1, 16'd412);
      send(8'hF0); send(8'h23);
      expect_out("e4_brk", 1'b0, 16'd412);

      // flipped parity
      base = err_pulses;
      send_frame(8'h2B, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 16'd0);
`ifdef PS2_PARITY_CHECK_EN
      chk("par_err", err_pulses - base, 1);
      expect_out("par_out", 1'b0, 16'd412);
      exp_step = 16'd412;
`else
      chk("par_err", err_pulses - base, 0);
      expect_out("par_out", 1'b1, 16'd437);
      send(8'hF0); send(8'h2B);
      expect_out("par_brk", 1'b0, 16'd437);
      exp_step = 16'd437;
`endif

      // bad stop bit
      base = err_pulses;
      send_frame(8'h34, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 16'd0);
      chk("stop_err", err_pulses - base, 1);
      expect_out("stop_out", 1'b0, exp_step);

      // timeout after 4 data bits of 0x3B
      base = err_pulses;
      ps2_bit(1'b0);
      ps2_bit(1'b1); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
      wait_clk(1900);
      chk("to_early", err_pulses - base, 0);
      wait_clk(400);
      chk("to_err", err_pulses - base, 1);
      send(8'h3B);
      expect_out("b4_make", 1'b1, 16'd617);
      chk("err_width", err_run_max, 1);

      // reset in the middle of a frame
      ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
      iRST_N = 1'b0;
      wait_clk(3);
      chk("mid_rst_key", oKEY_ON, 1'b0);
      chk("mid_rst_step", oSTEP, 16'd0);
      chk("mid_rst_err", oFRAME_ERR, 1'b0);
      iRST_N = 1'b1;
      wait_clk(5);
      send(8'h1B);
      expect_out("d4_make", 1'b1, 16'd367);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
